// File: rtl/fsm_pkg.sv
// Shared types and line constants for the UART transmitter.
package fsm_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_CFG_REQ,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_DONE
  } transmitter_fsm_e;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    EVEN = 2'b01,
    ODD  = 2'b10
  } parity_mode_e;

  localparam logic TX_LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_core.sv
// UART transmitter: start, 5..DATA_MAX_WIDTH data bits LSB first, optional parity,
// one or two stop bits, plus a long line-low configuration request.
module uart_tx_core
  import fsm_pkg::*;
#(
  parameter int unsigned DATA_MAX_WIDTH = 8,
  parameter int unsigned TICKS_PER_BIT  = 16,
  parameter int unsigned CFG_REQ_BITS   = 20
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      tick_i,
  input  logic                      tx_start_i,
  input  logic [DATA_MAX_WIDTH-1:0] data_i,
  input  logic [4:0]                data_bits_i,
  input  logic [1:0]                parity_mode_i,
  input  logic                      stop_bits_i,
  input  logic                      cfg_req_i,
  output logic                      tx_o,
  output logic                      tx_ready_o,
  output logic                      tx_done_o
);

  localparam int unsigned TICK_W  = $clog2(TICKS_PER_BIT);
  localparam int unsigned CNT_MAX = (CFG_REQ_BITS > DATA_MAX_WIDTH) ? CFG_REQ_BITS : DATA_MAX_WIDTH;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CFG_LAST  = CNT_W'(CFG_REQ_BITS - 1);
  localparam logic [4:0]        MIN_BITS  = 5'd5;
  localparam logic [4:0]        MAX_BITS  = 5'(DATA_MAX_WIDTH);

  transmitter_fsm_e            state_q, state_d;
  logic [TICK_W-1:0]           tick_q, tick_d;
  logic [CNT_W-1:0]            bit_q, bit_d;
  logic [CNT_W-1:0]            last_q, last_d;
  logic [DATA_MAX_WIDTH-1:0]   shift_q, shift_d;
  parity_mode_e                pmode_q, pmode_d;
  logic                        pbit_q, pbit_d;
  logic                        stop2_q, stop2_d;
  logic                        tx_q, tx_d;
  logic                        done_q, done_d;

  logic [4:0]                  nbits_c;
  logic [DATA_MAX_WIDTH-1:0]   masked_c;
  parity_mode_e                pmode_c;
  logic                        pbit_c;
  logic                        period_end;

  // Frame parameters captured at acceptance: clamped width, masked payload, parity.
  always_comb begin
    nbits_c = data_bits_i;
    if (data_bits_i < MIN_BITS) begin
      nbits_c = MIN_BITS;
    end else if (data_bits_i > MAX_BITS) begin
      nbits_c = MAX_BITS;
    end
    masked_c = '0;
    for (int unsigned i = 0; i < DATA_MAX_WIDTH; i++) begin
      if (i < 32'(nbits_c)) begin
        masked_c[i] = data_i[i];
      end
    end
    case (parity_mode_i)
      2'b01:   pmode_c = EVEN;
      2'b10:   pmode_c = ODD;
      default: pmode_c = NONE;
    endcase
    pbit_c = ^masked_c;
    if (pmode_c == ODD) begin
      pbit_c = ~pbit_c;
    end
  end

  assign period_end = tick_i && (tick_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    last_d  = last_q;
    shift_d = shift_q;
    pmode_d = pmode_q;
    pbit_d  = pbit_q;
    stop2_d = stop2_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    if (tick_i && (state_q != TX_IDLE)) begin
      tick_d = period_end ? '0 : tick_q + TICK_W'(1);
    end

    // tx_d tracks the line level of the state being entered, keeping tx_o registered.
    case (state_q)
      TX_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        if (cfg_req_i) begin
          state_d = TX_CFG_REQ;
          stop2_d = 1'b0;
          tx_d    = 1'b0;
        end else if (tx_start_i) begin
          state_d = TX_START;
          last_d  = CNT_W'(nbits_c - 5'd1);
          shift_d = masked_c;
          pmode_d = pmode_c;
          pbit_d  = pbit_c;
          stop2_d = stop_bits_i;
          tx_d    = 1'b0;
        end
      end
      TX_CFG_REQ: begin
        if (period_end) begin
          if (bit_q == CFG_LAST) begin
            state_d = TX_DONE;
            bit_d   = '0;
            tx_d    = TX_LINE_IDLE;
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end
      end
      TX_START: begin
        if (period_end) begin
          state_d = TX_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      TX_DATA: begin
        if (period_end) begin
          if (bit_q == last_q) begin
            bit_d = '0;
            if (pmode_q == NONE) begin
              state_d = TX_DONE;
              tx_d    = TX_LINE_IDLE;
            end else begin
              state_d = TX_PARITY;
              tx_d    = pbit_q;
            end
          end else begin
            bit_d   = bit_q + CNT_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      TX_PARITY: begin
        if (period_end) begin
          state_d = TX_DONE;
          bit_d   = '0;
          tx_d    = TX_LINE_IDLE;
        end
      end
      TX_DONE: begin
        if (period_end) begin
          if (stop2_q && (bit_q == '0)) begin
            bit_d = CNT_W'(1);
          end else begin
            state_d = TX_IDLE;
            bit_d   = '0;
            done_d  = 1'b1;
            tx_d    = TX_LINE_IDLE;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
        tick_d  = '0;
        bit_d   = '0;
        tx_d    = TX_LINE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= TX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      last_q  <= '0;
      shift_q <= '0;
      pmode_q <= NONE;
      pbit_q  <= 1'b0;
      stop2_q <= 1'b0;
      tx_q    <= TX_LINE_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      shift_q <= shift_d;
      pmode_q <= pmode_d;
      pbit_q  <= pbit_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx_o       = tx_q;
  assign tx_ready_o = (state_q == TX_IDLE);
  assign tx_done_o  = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: expected line waveform built as a list of bit periods.
module tb_uart_tx_core;

  localparam int DW   = 8;
  localparam int TPB  = 16;
  localparam int CFGB = 20;

  logic          clk = 1'b0;
  logic          rst_n_i;
  logic          tick_i;
  logic          tx_start_i;
  logic [DW-1:0] data_i;
  logic [4:0]    data_bits_i;
  logic [1:0]    parity_mode_i;
  logic          stop_bits_i;
  logic          cfg_req_i;
  logic          tx_o;
  logic          tx_ready_o;
  logic          tx_done_o;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  uart_tx_core #(
    .DATA_MAX_WIDTH (DW),
    .TICKS_PER_BIT  (TPB),
    .CFG_REQ_BITS   (CFGB)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n_i),
    .tick_i        (tick_i),
    .tx_start_i    (tx_start_i),
    .data_i        (data_i),
    .data_bits_i   (data_bits_i),
    .parity_mode_i (parity_mode_i),
    .stop_bits_i   (stop_bits_i),
    .cfg_req_i     (cfg_req_i),
    .tx_o          (tx_o),
    .tx_ready_o    (tx_ready_o),
    .tx_done_o     (tx_done_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"},    32'(tx_o),       32'(1));
    check({tag, "_ready"}, 32'(tx_ready_o), 32'(1));
    check({tag, "_done"},  32'(tx_done_o),  32'(0));
  endtask

  // One frame (or configuration request) starting on the next edge, checked every cycle.
  // Ticks arrive every div cycles, suspended for stall_len cycles from cycle stall_at.
  // abort_idx > 0 applies reset while bit period abort_idx is on the line.
  task automatic run_frame(input logic [DW-1:0] d, input int nb, input logic [1:0] pm,
                           input logic s2, input logic cfg, input int div,
                           input int stall_at, input int stall_len, input int abort_idx);
    logic bits[$];
    int   n, len, idx, tc, k, cyc;
    logic p, t, stalled;
    n = (nb < 5) ? 5 : ((nb > DW) ? DW : nb);
    if (cfg) begin
      repeat (CFGB) bits.push_back(1'b0);
      bits.push_back(1'b1);
    end else begin
      bits.push_back(1'b0);
      p = 1'b0;
      for (int i = 0; i < n; i++) begin
        bits.push_back(d[i]);
        p ^= d[i];
      end
      if (pm == 2'b01) bits.push_back(p);
      if (pm == 2'b10) bits.push_back(~p);
      bits.push_back(1'b1);
      if (s2) bits.push_back(1'b1);
    end
    len = bits.size();

    @(negedge clk);
    check("ready_before_start", 32'(tx_ready_o), 32'(1));
    data_i        = d;
    data_bits_i   = 5'(nb);
    parity_mode_i = pm;
    stop_bits_i   = s2;
    cfg_req_i     = cfg;
    tx_start_i    = 1'b1;
    tick_i        = 1'b1;
    @(posedge clk); #1;
    check("first_bit", 32'(tx_o), 32'(bits[0]));
    check("ready_busy", 32'(tx_ready_o), 32'(0));
    idx = 0; tc = 0; k = 0; cyc = 0;

    while (idx < len && cyc < 20000) begin
      @(negedge clk);
      if (abort_idx > 0 && idx == abort_idx) begin
        rst_n_i    = 1'b0;
        tx_start_i = 1'b0;
        cfg_req_i  = 1'b0;
        @(posedge clk); #1;
        check_idle("abort");
        @(negedge clk);
        rst_n_i = 1'b1;
        tick_i  = 1'b1;
        repeat (20) begin
          @(posedge clk); #1;
          check_idle("after_abort");
        end
        return;
      end
      stalled = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      if (stalled) begin
        tick_i = 1'b0;
      end else begin
        tick_i = ((k % div) == div - 1);
        k++;
      end
      data_i        = DW'($urandom);
      data_bits_i   = 5'($urandom);
      parity_mode_i = 2'($urandom);
      stop_bits_i   = 1'($urandom);
      tx_start_i    = 1'($urandom);
      cfg_req_i     = 1'($urandom);
      t = tick_i;
      @(posedge clk); #1;
      cyc++;
      if (t) begin
        tc++;
        if (tc == TPB) begin
          tc = 0;
          idx++;
        end
      end
      check("tx_line", 32'(tx_o), 32'((idx < len) ? bits[idx] : 1'b1));
      check("done_pulse", 32'(tx_done_o), 32'(idx == len));
      check("ready", 32'(tx_ready_o), 32'(idx == len));
    end
    check("frame_cycles", 32'(cyc), 32'(len * TPB * div + stall_len));
    tx_start_i = 1'b0;
    cfg_req_i  = 1'b0;
  endtask

  initial begin
    rst_n_i       = 1'b0;
    tick_i        = 1'b1;
    tx_start_i    = 1'b1;
    cfg_req_i     = 1'b1;
    data_i        = 8'hA5;
    data_bits_i   = 5'd8;
    parity_mode_i = 2'b01;
    stop_bits_i   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst_n_i    = 1'b1;
    tx_start_i = 1'b0;
    cfg_req_i  = 1'b0;
    @(posedge clk); #1;
    check_idle("post_reset");

    run_frame(8'h55, 8,  2'b00, 1'b0, 1'b0, 1, 0, 0, 0);   // 8N1
    run_frame(8'hC1, 7,  2'b01, 1'b1, 1'b0, 1, 0, 0, 0);   // 7E2
    run_frame(8'hFF, 8,  2'b10, 1'b0, 1'b0, 1, 0, 0, 0);   // 8O1
    run_frame(8'h3C, 8,  2'b00, 1'b0, 1'b1, 1, 0, 0, 0);   // cfg request beats tx_start
    run_frame(8'h00, 8,  2'b00, 1'b0, 1'b0, 3, 0, 0, 0);   // tick every 3rd cycle
    run_frame(8'hA5, 8,  2'b01, 1'b0, 1'b0, 1, 40, 60, 0); // tick held low mid-frame
    run_frame(8'hFF, 3,  2'b11, 1'b0, 1'b0, 1, 0, 0, 0);   // width clamps up to 5
    run_frame(8'h3C, 20, 2'b01, 1'b1, 1'b0, 1, 0, 0, 0);   // width clamps down to 8
    run_frame(8'h96, 8,  2'b00, 1'b0, 1'b0, 1, 0, 0, 4);   // reset in 4th data bit

    for (int r = 0; r < 10; r++) begin
      run_frame(DW'($urandom), $urandom_range(3, 18), 2'($urandom), 1'($urandom),
                ($urandom_range(0, 5) == 0), $urandom_range(1, 3),
                $urandom_range(0, 50), $urandom_range(0, 30), 0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
